// File: rtl/out_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// out_port_arbiter_if
// Bundles the requester and display-write signals of out_port_arbiter.
//   a_valid/a_port/a_data -> a_ready : requester A (CPU driver) write channel
//   b_valid/b_port/b_data -> b_ready : requester B (time-set engine) channel
//   write_out/out_port/out_data      : registered write to display registers
//   drop_count                       : saturating count of illegal-port drops
//   busy                             : FIFOs non-empty or write in flight
// master: the side driving requests (requesters / testbench)
// slave : the arbiter itself
// ---------------------------------------------------------------------------
interface out_port_arbiter_if;
    logic        a_valid;
    logic [3:0]  a_port;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_port;
    logic [15:0] b_data;
    logic        b_ready;
    logic        write_out;
    logic [3:0]  out_port;
    logic [15:0] out_data;
    logic [7:0]  drop_count;
    logic        busy;

    modport master (
        output a_valid, a_port, a_data, b_valid, b_port, b_data,
        input  a_ready, b_ready, write_out, out_port, out_data, drop_count, busy
    );

    modport slave (
        input  a_valid, a_port, a_data, b_valid, b_port, b_data,
        output a_ready, b_ready, write_out, out_port, out_data, drop_count, busy
    );
endinterface

// File: rtl/out_port_arbiter.sv
// ---------------------------------------------------------------------------
// out_port_arbiter
// Two requesters (A, B) each feed a DEPTH-entry {port, data} FIFO. Every
// cycle at most one FIFO head is popped, round-robin when both hold data.
// A popped entry aimed at a legal port (< NPORTS) becomes a one-cycle
// registered write strobe; an illegal one is dropped and counted.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : out_port_arbiter_if.slave (request channels, write outputs,
//           drop_count, busy)
// ---------------------------------------------------------------------------
module out_port_arbiter #(
    parameter int DEPTH  = 2,
    parameter int NPORTS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    out_port_arbiter_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Round-robin pointer names the requester preferred on the next contended pop
    typedef enum logic {PREF_A = 1'b0, PREF_B = 1'b1} rr_t;

    logic [19:0]   mem_a [DEPTH];
    logic [19:0]   mem_b [DEPTH];
    logic [AW-1:0] wr_a, rd_a, wr_b, rd_b;
    logic [CW-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
    logic          rdy_a, rdy_b;
    logic          push_a, push_b, pop_a, pop_b, pop_any;
    rr_t           rr;
    logic [19:0]   head;
    logic          head_legal;

    logic          vld_p1;
    logic [3:0]    out_port_p1;
    logic [15:0]   out_data_p1;
    logic [7:0]    drop_cnt;

    // ---- stage p0: FIFO handshake and arbitration ----
    // Ready is registered, so a full FIFO refuses even when it pops this cycle.
    assign push_a  = bus.a_valid & rdy_a;
    assign push_b  = bus.b_valid & rdy_b;
    assign pop_a   = (cnt_a != '0) & ((cnt_b == '0) | (rr == PREF_A));
    assign pop_b   = (cnt_b != '0) & ~pop_a;
    assign pop_any = pop_a | pop_b;

    assign head       = pop_a ? mem_a[rd_a] : mem_b[rd_b];
    assign head_legal = ({28'd0, head[19:16]} < 32'(NPORTS));

    assign cnt_a_nxt = cnt_a + CW'(push_a) - CW'(pop_a);
    assign cnt_b_nxt = cnt_b + CW'(push_b) - CW'(pop_b);

    // Storage carries no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push_a) mem_a[wr_a] <= {bus.a_port, bus.a_data};
        if (!reset && push_b) mem_b[wr_b] <= {bus.b_port, bus.b_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
            wr_a  <= '0;
            rd_a  <= '0;
            wr_b  <= '0;
            rd_b  <= '0;
            rdy_a <= 1'b1;
            rdy_b <= 1'b1;
            rr    <= PREF_A;
        end else begin
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
            rdy_a <= (cnt_a_nxt != CW'(DEPTH));
            rdy_b <= (cnt_b_nxt != CW'(DEPTH));
            if (push_a) wr_a <= wr_a + AW'(1);
            if (pop_a)  rd_a <= rd_a + AW'(1);
            if (push_b) wr_b <= wr_b + AW'(1);
            if (pop_b)  rd_b <= rd_b + AW'(1);
            // Pointer moves on every pop, discarded entries included
            if (pop_a)      rr <= PREF_B;
            else if (pop_b) rr <= PREF_A;
        end
    end

    // ---- stage p1: registered write strobe and drop counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            out_port_p1 <= '0;
            out_data_p1 <= '0;
            drop_cnt    <= '0;
        end else begin
            vld_p1 <= pop_any & head_legal;
            // Port/data hold their last value when nothing legal is popped
            if (pop_any && head_legal) begin
                out_port_p1 <= head[19:16];
                out_data_p1 <= head[15:0];
            end
            if (pop_any && !head_legal && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign bus.a_ready    = rdy_a;
    assign bus.b_ready    = rdy_b;
    assign bus.write_out  = vld_p1;
    assign bus.out_port   = out_port_p1;
    assign bus.out_data   = out_data_p1;
    assign bus.drop_count = drop_cnt;
    assign bus.busy       = (cnt_a != '0) | (cnt_b != '0) | vld_p1;

endmodule
